// File: rtl/alu_exec_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_exec_stage_pkg                                           |
// | Description : Shared ALU definitions: the operation encoding, the result   |
// |               the ALU returns for NOP or unknown ops, and the default      |
// |               width of the destination tag.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package alu_exec_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_NOP  = 4'd10
  } alu_op_t;

  // Result the ALU produces for NOP and for any undefined encoding.
  localparam logic [31:0] ALU_NOP_RESULT = 32'hE2202;

  // System default for the destination tag width (warp id + rd).
  localparam int EXEC_TAG_W = 8;

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu                                                          |
// | Description : Purely combinational 32-bit integer ALU.                     |
// |   op     in  alu_op_t  operation                                           |
// |   a      in  32        operand A                                           |
// |   b      in  32        operand B (shifts use b[4:0])                       |
// |   result out 32        result; ALU_NOP_RESULT for NOP/unknown ops          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu
  import alu_exec_stage_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  always_comb begin
    result = ALU_NOP_RESULT;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << b[4:0];
      ALU_SRL:  result = a >> b[4:0];
      ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT:  result = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {31'd0, (a < b)};
      default:  result = ALU_NOP_RESULT;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_exec_stage_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync_fifo                                                    |
// | Description : Single-clock FIFO with registered storage and a head that    |
// |               is read straight out of storage (no input-to-output path).   |
// |   clk, rst_n   in   clock, asynchronous active-low reset                   |
// |   flush        in   synchronous clear of pointers and count                |
// |   push         in   write request (taken only when push_ready)             |
// |   push_data    in   DATA_W write data                                      |
// |   push_ready   out  not full, or full with a pop this cycle                |
// |   pop          in   read request (ignored when empty)                      |
// |   head_data    out  DATA_W oldest entry                                    |
// |   count        out  occupancy, log2(DEPTH)+1 bits                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2   // power of two, >= 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  output logic                       push_ready,
  input  logic                       pop,
  output logic [DATA_W-1:0]          head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_fire;
  logic              pop_fire;

  assign pop_fire   = pop && (count != '0);
  // A pop in the same cycle frees the slot the push will land in.
  assign push_ready = (count != FULL_COUNT) || pop_fire;
  assign push_fire  = push && push_ready;
  assign head_data  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_fire && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_fire, pop_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_exec_stage                                               |
// | Description : Registered ALU execute stage. S1 captures the issued         |
// |               instruction (operand B already muxed with the immediate);    |
// |               the ALU result from S1 is queued in an output FIFO toward    |
// |               writeback.                                                   |
// |   clk, rst_n              clock, asynchronous active-low reset             |
// |   flush                   kill S1 and FIFO contents at the next edge       |
// |   in_valid / in_ready     dispatch handshake                               |
// |   in_alu_op, in_operand_a, in_operand_b, in_use_imm, in_imm,               |
// |   in_tag, in_wb_en        issued instruction                               |
// |   out_valid / out_ready   writeback handshake                              |
// |   out_result, out_tag, out_wb_en   FIFO head                               |
// |   busy                    S1 valid or FIFO non-empty                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int TAG_W      = EXEC_TAG_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_t          in_alu_op,
  input  logic [31:0]      in_operand_a,
  input  logic [31:0]      in_operand_b,
  input  logic             in_use_imm,
  input  logic [31:0]      in_imm,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_wb_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_wb_en,
  output logic             busy
);

  localparam int ENTRY_W = 32 + TAG_W + 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  // S1 registers
  logic             s1_valid;
  alu_op_t          s1_op;
  logic [31:0]      s1_a;
  logic [31:0]      s1_b;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_wb_en;

  logic               s1_advance;
  logic               accept;
  logic               pop;
  logic               fifo_push_ready;
  logic [CNT_W-1:0]   fifo_count;
  logic [31:0]        alu_result;
  logic               push_wb_en;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;

  assign out_valid  = (fifo_count != '0);
  assign pop        = out_valid && out_ready;
  assign s1_advance = s1_valid && fifo_push_ready;
  assign in_ready   = !flush && (!s1_valid || s1_advance);
  assign accept     = in_valid && in_ready;
  assign busy       = s1_valid || out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= ALU_NOP;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
      s1_wb_en <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_op    <= in_alu_op;
      s1_a     <= in_operand_a;
      s1_b     <= in_use_imm ? in_imm : in_operand_b;
      s1_tag   <= in_tag;
      s1_wb_en <= in_wb_en;
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  alu u_alu (
    .op     (s1_op),
    .a      (s1_a),
    .b      (s1_b),
    .result (alu_result)
  );

  // NOP flows through to keep ordering but never writes a register.
  assign push_wb_en = s1_wb_en && (s1_op != ALU_NOP);
  assign push_entry = {alu_result, s1_tag, push_wb_en};

  sync_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push       (s1_advance),
    .push_data  (push_entry),
    .push_ready (fifo_push_ready),
    .pop        (pop),
    .head_data  (head_entry),
    .count      (fifo_count)
  );

  assign out_result = head_entry[ENTRY_W-1 -: 32];
  assign out_tag    = head_entry[TAG_W:1];
  assign out_wb_en  = head_entry[0];

endmodule
`default_nettype wire
